// File: rtl/st7735_bus_decoder_if.sv
// rtl/st7735_bus_decoder_if.sv - ST7735 4-wire write bus as seen by the display driver and the decoder
interface st7735_bus_decoder_if;
    logic lcd_cs;
    logic lcd_clk;
    logic lcd_mosi;
    logic lcd_dc;
    logic lcd_reset;

    modport master (output lcd_cs, lcd_clk, lcd_mosi, lcd_dc, lcd_reset);
    modport slave  (input  lcd_cs, lcd_clk, lcd_mosi, lcd_dc, lcd_reset);
endinterface

// File: rtl/st7735_bus_decoder.sv
// rtl/st7735_bus_decoder.sv - oversampling ST7735 bus receiver, command decoder and RGB565 pixel writer
module st7735_bus_decoder #(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 80,
    parameter int COORD_W = 8
) (
    input  logic                 SYSTEM_CLK,
    input  logic                 SYSTEM_RST,
    st7735_bus_decoder_if.slave  lcd,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_byte,
    output logic                 param_valid,
    output logic [7:0]           param_byte,
    output logic [4:0]           param_index,
    output logic                 pixel_valid,
    output logic [COORD_W-1:0]   pixel_x,
    output logic [COORD_W-1:0]   pixel_y,
    output logic [15:0]          pixel_color,
    output logic                 frame_done,
    output logic                 sleep_out,
    output logic                 display_on,
    output logic                 invert_on,
    output logic [COORD_W-1:0]   win_xs,
    output logic [COORD_W-1:0]   win_xe,
    output logic [COORD_W-1:0]   win_ys,
    output logic [COORD_W-1:0]   win_ye
);
    typedef enum logic [1:0] {IDLE, CMD_PARAM, RAMWR_HI, RAMWR_LO} state_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [2:0]  bit_cnt;
        logic [6:0]  shift;
        logic [4:0]  pidx;
        logic [7:0]  msb;
        coord_t      cur_x;
        coord_t      cur_y;
        logic        cmd_valid;
        logic [7:0]  cmd_byte;
        logic        param_valid;
        logic [7:0]  param_byte;
        logic [4:0]  param_index;
        logic        pixel_valid;
        coord_t      pixel_x;
        coord_t      pixel_y;
        logic [15:0] pixel_color;
        logic        frame_done;
        logic        sleep_out;
        logic        display_on;
        logic        invert_on;
        coord_t      win_xs;
        coord_t      win_xe;
        coord_t      win_ys;
        coord_t      win_ye;
    } regs_t;

    function automatic regs_t cleared();
        regs_t c;
        c        = '0;
        c.win_xe = coord_t'(WIDTH - 1);
        c.win_ye = coord_t'(HEIGHT - 1);
        return c;
    endfunction

    // Address bytes land in a 16-bit view of the coordinate, then truncate back.
    function automatic coord_t set_hi(coord_t old, logic [7:0] b);
        logic [15:0] w;
        w       = 16'(old);
        w[15:8] = b;
        return coord_t'(w);
    endfunction

    function automatic coord_t set_lo(coord_t old, logic [7:0] b);
        logic [15:0] w;
        w      = 16'(old);
        w[7:0] = b;
        return coord_t'(w);
    endfunction

    logic [1:0] cs_s, sclk_s, mosi_s, dc_s, rstn_s;
    logic       sclk_prev;

    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RST) begin
        if (SYSTEM_RST) begin
            cs_s      <= 2'b11;
            sclk_s    <= 2'b11;
            mosi_s    <= 2'b00;
            dc_s      <= 2'b00;
            rstn_s    <= 2'b00;
            sclk_prev <= 1'b1;
        end else begin
            cs_s      <= {cs_s[0], lcd.lcd_cs};
            sclk_s    <= {sclk_s[0], lcd.lcd_clk};
            mosi_s    <= {mosi_s[0], lcd.lcd_mosi};
            dc_s      <= {dc_s[0], lcd.lcd_dc};
            rstn_s    <= {rstn_s[0], lcd.lcd_reset};
            sclk_prev <= sclk_s[1];
        end
    end

    regs_t      r, n;
    state_t     state, next_state;
    logic       rise, cs_active, strobe;
    logic [7:0] byte_in;

    assign rise      = sclk_s[1] & ~sclk_prev;
    assign cs_active = ~cs_s[1];
    assign strobe    = rise & cs_active & (r.bit_cnt == 3'd7);
    assign byte_in   = {r.shift, mosi_s[1]};

    always_comb begin
        n             = r;
        next_state    = state;
        n.cmd_valid   = 1'b0;
        n.param_valid = 1'b0;
        n.pixel_valid = 1'b0;
        n.frame_done  = 1'b0;

        if (!cs_active) begin
            n.bit_cnt = '0;
        end else if (rise) begin
            n.shift   = {r.shift[5:0], mosi_s[1]};
            n.bit_cnt = r.bit_cnt + 3'd1;
        end

        if (strobe && !dc_s[1]) begin
            n.cmd_valid   = 1'b1;
            n.cmd_byte    = byte_in;
            n.pidx        = '0;
            n.param_index = '0;
            next_state    = IDLE;
            case (byte_in)
                8'h11: n.sleep_out  = 1'b1;
                8'h10: n.sleep_out  = 1'b0;
                8'h29: n.display_on = 1'b1;
                8'h28: n.display_on = 1'b0;
                8'h21: n.invert_on  = 1'b1;
                8'h20: n.invert_on  = 1'b0;
                8'h01: begin
                    n           = cleared();
                    n.cmd_valid = 1'b1;
                    n.cmd_byte  = byte_in;
                end
                8'h2C: begin
                    n.cur_x    = r.win_xs;
                    n.cur_y    = r.win_ys;
                    next_state = RAMWR_HI;
                end
                default: next_state = CMD_PARAM;
            endcase
        end else if (strobe) begin
            case (state)
                RAMWR_HI: begin
                    n.msb      = byte_in;
                    next_state = RAMWR_LO;
                end
                RAMWR_LO: begin
                    n.pixel_valid = 1'b1;
                    n.pixel_x     = r.cur_x;
                    n.pixel_y     = r.cur_y;
                    n.pixel_color = {r.msb, byte_in};
                    next_state    = RAMWR_HI;
                    // Equality-only wrap keeps degenerate windows running modulo 2^COORD_W.
                    if (r.cur_x == r.win_xe && r.cur_y == r.win_ye) begin
                        n.frame_done = 1'b1;
                        n.cur_x      = r.win_xs;
                        n.cur_y      = r.win_ys;
                    end else if (r.cur_x == r.win_xe) begin
                        n.cur_x = r.win_xs;
                        n.cur_y = r.cur_y + coord_t'(1);
                    end else begin
                        n.cur_x = r.cur_x + coord_t'(1);
                    end
                end
                default: begin
                    n.param_valid = 1'b1;
                    n.param_byte  = byte_in;
                    n.param_index = r.pidx;
                    if (r.pidx != 5'd31)
                        n.pidx = r.pidx + 5'd1;
                    if (state == CMD_PARAM && r.cmd_byte == 8'h2A) begin
                        case (r.pidx)
                            5'd0:    n.win_xs = set_hi(r.win_xs, byte_in);
                            5'd1:    n.win_xs = set_lo(r.win_xs, byte_in);
                            5'd2:    n.win_xe = set_hi(r.win_xe, byte_in);
                            5'd3:    n.win_xe = set_lo(r.win_xe, byte_in);
                            default: ;
                        endcase
                    end else if (state == CMD_PARAM && r.cmd_byte == 8'h2B) begin
                        case (r.pidx)
                            5'd0:    n.win_ys = set_hi(r.win_ys, byte_in);
                            5'd1:    n.win_ys = set_lo(r.win_ys, byte_in);
                            5'd2:    n.win_ye = set_hi(r.win_ye, byte_in);
                            5'd3:    n.win_ye = set_lo(r.win_ye, byte_in);
                            default: ;
                        endcase
                    end
                end
            endcase
        end

        // Panel reset wins over a byte completing in the same cycle.
        if (!rstn_s[1]) begin
            n          = cleared();
            next_state = IDLE;
        end
    end

    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RST) begin
        if (SYSTEM_RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RST) begin
        if (SYSTEM_RST)
            r <= cleared();
        else
            r <= n;
    end

    assign cmd_valid   = r.cmd_valid;
    assign cmd_byte    = r.cmd_byte;
    assign param_valid = r.param_valid;
    assign param_byte  = r.param_byte;
    assign param_index = r.param_index;
    assign pixel_valid = r.pixel_valid;
    assign pixel_x     = r.pixel_x;
    assign pixel_y     = r.pixel_y;
    assign pixel_color = r.pixel_color;
    assign frame_done  = r.frame_done;
    assign sleep_out   = r.sleep_out;
    assign display_on  = r.display_on;
    assign invert_on   = r.invert_on;
    assign win_xs      = r.win_xs;
    assign win_xe      = r.win_xe;
    assign win_ys      = r.win_ys;
    assign win_ye      = r.win_ye;
endmodule
